// File: rtl/payout_ledger.sv
// payout_ledger: credit ledger for a three-reel slot machine.
// Deducts the wager when a spin is accepted, credits bet * multiplier on
// settle (saturating at MAX_BALANCE), and maintains a BCD copy of the
// balance with a sequential double-dabble converter.
module payout_ledger #(
    parameter int unsigned START_BALANCE = 100,
    parameter int unsigned MAX_BALANCE   = 999
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       spin_start,
    input  logic       payout,
    input  logic [2:0] icon1,
    input  logic [2:0] icon2,
    input  logic [2:0] icon3,
    input  logic [6:0] bet,
    output logic [9:0] balance,
    output logic [9:0] last_win,
    output logic [3:0] balance_h,
    output logic [3:0] balance_t,
    output logic [3:0] balance_o,
    output logic       bcd_valid,
    output logic       insufficient,
    output logic       armed
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam logic [9:0]  START_BAL = 10'(START_BALANCE);
    localparam logic [10:0] MAX_SUM   = 11'(MAX_BALANCE);
    localparam logic [11:0] START_DIG = {4'(START_BALANCE / 100),
                                         4'((START_BALANCE / 10) % 10),
                                         4'(START_BALANCE % 10)};

    logic [1:0]  state_q, state_d;
    logic [9:0]  balance_q, balance_d;
    logic [9:0]  last_win_q, last_win_d;
    logic [6:0]  bet_q, bet_d;
    logic        ins_q, ins_d;
    logic [2:0]  ic1_q, ic1_d, ic2_q, ic2_d, ic3_q, ic3_d;

    logic [6:0]  bet_clamp;
    logic [3:0]  mult;
    logic [9:0]  win;
    logic [10:0] sum;

    // Converter state: {hundreds, tens, ones, binary} shift register
    logic [21:0] sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [11:0] dig_q, dig_d;
    logic [21:0] adj;
    logic [21:0] shifted;
    logic        bal_chg;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Settle arithmetic from the icons captured when payout was accepted
    always_comb begin
        bet_clamp = (bet > 7'd99) ? 7'd99 : bet;
        mult      = 4'd0;
        if (ic1_q == ic2_q && ic2_q == ic3_q)
            mult = (ic1_q == 3'd7) ? 4'd10 : 4'd5;
        else if (ic1_q == ic2_q || ic2_q == ic3_q || ic1_q == ic3_q)
            mult = 4'd2;
        win = {3'b000, bet_q} * {6'b000000, mult};
        sum = {1'b0, balance_q} + {1'b0, win};
    end

    // Ledger FSM next-state
    always_comb begin
        state_d    = state_q;
        balance_d  = balance_q;
        last_win_d = last_win_q;
        bet_d      = bet_q;
        ins_d      = ins_q;
        ic1_d      = ic1_q;
        ic2_d      = ic2_q;
        ic3_d      = ic3_q;
        case (state_q)
            S_IDLE: begin
                if (spin_start) begin
                    if (bet_clamp != 7'd0 && {3'b000, bet_clamp} <= balance_q) begin
                        bet_d     = bet_clamp;
                        balance_d = balance_q - {3'b000, bet_clamp};
                        ins_d     = 1'b0;
                        state_d   = S_ARMED;
                    end else begin
                        ins_d = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (payout) begin
                    ic1_d   = icon1;
                    ic2_d   = icon2;
                    ic3_d   = icon3;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                last_win_d = win;
                balance_d  = (sum > MAX_SUM) ? MAX_SUM[9:0] : sum[9:0];
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ledger registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            balance_q  <= START_BAL;
            last_win_q <= '0;
            bet_q      <= '0;
            ins_q      <= 1'b0;
            ic1_q      <= '0;
            ic2_q      <= '0;
            ic3_q      <= '0;
        end else begin
            state_q    <= state_d;
            balance_q  <= balance_d;
            last_win_q <= last_win_d;
            bet_q      <= bet_d;
            ins_q      <= ins_d;
            ic1_q      <= ic1_d;
            ic2_q      <= ic2_d;
            ic3_q      <= ic3_d;
        end
    end

    // Double-dabble step; a balance update (re)loads the converter on the
    // same edge that commits it, so bcd_valid falls together with the change
    always_comb begin
        bal_chg = (balance_d != balance_q);
        adj     = {add3(sh_q[21:18]), add3(sh_q[17:14]), add3(sh_q[13:10]), sh_q[9:0]};
        shifted = {adj[20:0], 1'b0};
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        dig_d   = dig_q;
        if (bal_chg) begin
            sh_d    = {12'd0, balance_d};
            cnt_d   = 4'd10;
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end else if (busy_q) begin
            sh_d  = shifted;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                dig_d   = shifted[21:10];
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    // Converter registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            dig_q   <= START_DIG;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            dig_q   <= dig_d;
        end
    end

    assign balance      = balance_q;
    assign last_win     = last_win_q;
    assign balance_h    = dig_q[11:8];
    assign balance_t    = dig_q[7:4];
    assign balance_o    = dig_q[3:0];
    assign bcd_valid    = valid_q;
    assign insufficient = ins_q;
    assign armed        = (state_q == S_ARMED);

endmodule

// File: tb/tb_payout_ledger.sv
// Scoreboard bench for payout_ledger: stimulus pushes expected settled
// ledger values; a monitor pops and compares each time a BCD conversion
// completes (bcd_valid rising).
module tb_payout_ledger;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       spin_start = 1'b0;
    logic       payout = 1'b0;
    logic [2:0] icon1 = '0, icon2 = '0, icon3 = '0;
    logic [6:0] bet = '0;
    logic [9:0] balance, last_win;
    logic [3:0] balance_h, balance_t, balance_o;
    logic       bcd_valid, insufficient, armed;

    payout_ledger #(.START_BALANCE(100), .MAX_BALANCE(999)) dut (
        .clock(clock), .resetn(resetn), .spin_start(spin_start), .payout(payout),
        .icon1(icon1), .icon2(icon2), .icon3(icon3), .bet(bet),
        .balance(balance), .last_win(last_win),
        .balance_h(balance_h), .balance_t(balance_t), .balance_o(balance_o),
        .bcd_valid(bcd_valid), .insufficient(insufficient), .armed(armed)
    );

    always #10 clock = ~clock;

    typedef struct { int bal; int lw; } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // reference ledger state
    int m_bal = 100, m_lw = 0, m_bet = 0, m_ins = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_mult(input int a, input int b, input int c);
        if (a == b && b == c) return (a == 7) ? 10 : 5;
        if (a == b || b == c || a == c) return 2;
        return 0;
    endfunction

    task automatic push_exp(input int b, input int l);
        exp_t e;
        e.bal = b;
        e.lw  = l;
        exp_q.push_back(e);
    endtask

    // monitor: compare on every completed conversion
    initial begin
        bit prev;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (!mon_en || !resetn) begin
                prev = bcd_valid;
            end else begin
                if (bcd_valid && !prev) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_conversion: balance=%0d with nothing expected", balance);
                    end else begin
                        e = exp_q.pop_front();
                        chk("conv_balance", balance, e.bal);
                        chk("conv_bcd_h", balance_h, e.bal / 100);
                        chk("conv_bcd_t", balance_t, (e.bal / 10) % 10);
                        chk("conv_bcd_o", balance_o, e.bal % 10);
                        chk("conv_last_win", last_win, e.lw);
                    end
                end
                prev = bcd_valid;
            end
        end
    end

    task automatic settle_wait();
        int n = 0;
        while (!bcd_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!bcd_valid) begin
            total++;
            bad++;
            $display("FAIL bcd_timeout: bcd_valid=%0d required 1 within 40 cycles", bcd_valid);
        end
        @(negedge clock);
    endtask

    task automatic do_spin(input int b, input bit with_pay, input bit push, output bit acc);
        int c;
        c = (b > 99) ? 99 : b;
        @(negedge clock);
        bet        = 7'(b);
        spin_start = 1'b1;
        payout     = with_pay;
        icon1 = 3'd7; icon2 = 3'd7; icon3 = 3'd7;
        @(negedge clock);
        spin_start = 1'b0;
        payout     = 1'b0;
        acc = (c != 0 && c <= m_bal);
        if (acc) begin
            m_bal -= c;
            m_bet  = c;
            m_ins  = 0;
            if (push) push_exp(m_bal, m_lw);
        end else begin
            m_ins = 1;
        end
        chk("spin_balance", balance, m_bal);
        chk("spin_insufficient", insufficient, m_ins);
        chk("spin_armed", armed, int'(acc));
        if (acc) chk("spin_bcd_valid_drop", bcd_valid, 0);
        if (acc && push) settle_wait();
    endtask

    task automatic do_payout(input int a, input int b, input int c, input bit pushed);
        int win, nb;
        @(negedge clock);
        icon1 = 3'(a); icon2 = 3'(b); icon3 = 3'(c);
        payout = 1'b1;
        @(negedge clock);
        payout = 1'b0;
        icon1 = 3'($urandom); icon2 = 3'($urandom); icon3 = 3'($urandom);
        @(negedge clock);
        win = m_bet * ref_mult(a, b, c);
        nb  = m_bal + win;
        if (nb > 999) nb = 999;
        if (nb != m_bal || !pushed) push_exp(nb, win);
        m_bal = nb;
        m_lw  = win;
        chk("settle_balance", balance, m_bal);
        chk("settle_last_win", last_win, m_lw);
        chk("settle_armed", armed, 0);
        settle_wait();
    endtask

    task automatic do_reset_async();
        mon_en = 1'b0;
        #3;
        resetn = 1'b0;
        #2;
        chk("rst_balance", balance, 100);
        chk("rst_bcd_h", balance_h, 1);
        chk("rst_bcd_t", balance_t, 0);
        chk("rst_bcd_o", balance_o, 0);
        chk("rst_bcd_valid", bcd_valid, 1);
        chk("rst_last_win", last_win, 0);
        chk("rst_insufficient", insufficient, 0);
        chk("rst_armed", armed, 0);
        exp_q.delete();
        m_bal = 100; m_lw = 0; m_bet = 0; m_ins = 0;
        @(negedge clock);
        #5 resetn = 1'b1;
        @(negedge clock);
        @(negedge clock);
        mon_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int b, p, mode, v, g;
        int ia, ib, ic;

        // power-on reset
        #25;
        chk("por_balance", balance, 100);
        chk("por_bcd_valid", bcd_valid, 1);
        @(negedge clock);
        #5 resetn = 1'b1;
        @(negedge clock);
        chk("init_bcd_h", balance_h, 1);
        chk("init_bcd_t", balance_t, 0);
        chk("init_bcd_o", balance_o, 0);
        chk("init_armed", armed, 0);
        chk("init_insufficient", insufficient, 0);
        chk("init_last_win", last_win, 0);
        mon_en = 1'b1;

        // triple match: 100 -> 90 -> 140
        do_spin(10, 0, 1, acc);
        do_payout(3, 3, 3, 1);
        // jackpot and a pair
        do_spin(20, 0, 1, acc);
        do_payout(7, 7, 7, 1);
        do_spin(5, 0, 1, acc);
        do_payout(1, 2, 1, 1);
        // saturation at 999, then clamped wager of 127 deducts 99
        do_spin(99, 0, 0, acc);
        do_payout(7, 7, 7, 0);
        chk("sat_balance", balance, 999);
        do_spin(127, 0, 0, acc);
        do_payout(0, 1, 2, 0);

        // payout in IDLE is ignored
        @(negedge clock);
        icon1 = 3'd7; icon2 = 3'd7; icon3 = 3'd7;
        payout = 1'b1;
        @(negedge clock);
        payout = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_payout_balance", balance, m_bal);
        chk("idle_payout_armed", armed, 0);

        // spin_start while ARMED is ignored
        do_spin(15, 0, 0, acc);
        @(negedge clock);
        bet = 7'd40;
        spin_start = 1'b1;
        @(negedge clock);
        spin_start = 1'b0;
        @(negedge clock);
        chk("armed_spin_balance", balance, m_bal);
        chk("armed_spin_armed", armed, 1);
        do_payout(4, 4, 2, 0);

        // simultaneous spin_start + payout in IDLE
        do_spin(12, 1, 0, acc);
        @(negedge clock);
        @(negedge clock);
        chk("simul_balance", balance, m_bal);
        chk("simul_armed", armed, 1);
        do_payout(5, 5, 5, 0);

        // randomized play
        for (int k = 0; k < 40; k++) begin
            b    = $urandom_range(0, 127);
            p    = $urandom_range(0, 1);
            mode = $urandom_range(0, 3);
            v    = $urandom_range(0, 7);
            ia = v; ib = v; ic = v;
            if (mode == 0) begin
                ia = 7; ib = 7; ic = 7;
            end else if (mode == 2) begin
                ic = $urandom_range(0, 7);
            end else if (mode == 3) begin
                ia = $urandom_range(0, 7);
                ib = $urandom_range(0, 7);
                ic = $urandom_range(0, 7);
            end
            do_spin(b, 0, p[0], acc);
            if (acc) begin
                g = $urandom_range(0, 2);
                repeat (g) @(negedge clock);
                do_payout(ia, ib, ic, p[0]);
            end
            settle_wait();
        end

        // insufficient funds
        do_reset_async();
        do_spin(70, 0, 1, acc);
        do_payout(0, 1, 2, 1);
        chk("drain_balance", balance, 30);
        do_spin(40, 0, 0, acc);
        chk("reject_insufficient", insufficient, 1);
        chk("reject_armed", armed, 0);
        do_spin(30, 0, 1, acc);
        chk("exact_bet_balance", balance, 0);
        do_payout(1, 2, 3, 1);
        do_spin(0, 0, 0, acc);
        do_spin(5, 0, 0, acc);
        chk("zero_balance_insufficient", insufficient, 1);

        // reset mid-conversion after a win
        do_reset_async();
        do_spin(10, 0, 1, acc);
        @(negedge clock);
        icon1 = 3'd3; icon2 = 3'd3; icon3 = 3'd3;
        payout = 1'b1;
        @(negedge clock);
        payout = 1'b0;
        repeat (3) @(negedge clock);
        do_reset_async();

        // reset while armed; a later payout credits nothing
        do_spin(20, 0, 0, acc);
        do_reset_async();
        @(negedge clock);
        icon1 = 3'd7; icon2 = 3'd7; icon3 = 3'd7;
        payout = 1'b1;
        @(negedge clock);
        payout = 1'b0;
        repeat (15) @(negedge clock);
        chk("post_reset_balance", balance, 100);
        chk("post_reset_last_win", last_win, 0);

        settle_wait();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations: %0d left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/payout_ledger.md
PAYOUT_LEDGER -- requirements
Module: payout_ledger

Interface
REQ-001 Parameter START_BALANCE, default 100: balance loaded at reset, range 1..999.
REQ-002 Parameter MAX_BALANCE, default 999: saturation ceiling for balance.
REQ-003 clock  in  1  rising-edge system clock (50 MHz).
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 spin_start  in  1  one-cycle pulse requesting a new spin (bet deduction).
REQ-006 payout  in  1  one-cycle pulse marking spin settled (control PAY state).
REQ-007 icon1, icon2, icon3  in  3 each  final reel symbols, stable while payout is high.
REQ-008 bet  in  7  requested wager, binary; values above 99 are treated as 99.
REQ-009 balance  out  10  current credit balance, binary 0..MAX_BALANCE.
REQ-010 last_win  out  10  credits awarded by the most recent settle.
REQ-011 balance_h, balance_t, balance_o  out  4 each  BCD hundreds/tens/ones of balance.
REQ-012 bcd_valid  out  1  high when the BCD digits match balance.
REQ-013 insufficient  out  1  high after a rejected spin_start.
REQ-014 armed  out  1  high while a spin is accepted and awaiting payout.

Function
REQ-015 Ledger FSM states: IDLE, ARMED, SETTLE; IDLE after reset.
REQ-016 IDLE + spin_start, clamped bet nonzero and <= balance: latch clamped bet into bet_q, balance -= bet_q on the same edge, clear insufficient, go ARMED.
REQ-017 IDLE + spin_start, bet == 0 or clamped bet > balance: balance unchanged, insufficient set to 1, remain IDLE.
REQ-018 ARMED: spin_start ignored; payout pulse -> SETTLE on next edge; armed = 1 only in ARMED.
REQ-019 payout in IDLE or SETTLE is ignored.
REQ-020 SETTLE, one cycle: multiplier = 10 if all three icons equal and equal 7; 5 if all three equal otherwise; 2 if exactly two equal; 0 otherwise.
REQ-021 SETTLE: win = bet_q * multiplier (10-bit, max 990), last_win <= win, balance <= min(balance + win, MAX_BALANCE) using an 11-bit intermediate sum; next state IDLE.
REQ-022 Icons are sampled when payout is accepted in ARMED and held in registers for SETTLE.
REQ-023 BCD converter: sequential shift-add-3 (double dabble), one load cycle plus 10 shift cycles = 11 cycles per conversion.
REQ-024 Any cycle in which balance changes starts a conversion on the next edge; bcd_valid drops to 0 in that same next cycle.
REQ-025 Balance change during an active conversion aborts it and restarts from the new balance.
REQ-026 balance_h/t/o hold their previous values during conversion and update only on completion, when bcd_valid returns to 1.
REQ-027 Simultaneous spin_start and payout in IDLE: spin_start is processed, payout ignored.
REQ-028 Balance never underflows: deduction only when bet_q <= balance.

Reset
REQ-029 resetn low, asynchronously: state IDLE, balance = START_BALANCE, last_win = 0, bet_q = 0, insufficient = 0, armed = 0.
REQ-030 Reset: BCD digits = START_BALANCE digits (1,0,0 at default), bcd_valid = 1, converter idle.
REQ-031 Reset asserted mid-spin or mid-conversion discards the bet and the conversion; no payout is credited afterward.

Verification
REQ-032 Reset, bet=10, spin_start, payout with icons 3,3,3: balance 100->90->140, last_win=50; after 11 cycles BCD = 1,4,0 with bcd_valid=1.
REQ-033 balance 90, bet=20, icons 7,7,7: balance 70 then 270, last_win=200; icons 1,2,1 with bet=5: 265 then 275, last_win=10.
REQ-034 balance 30, bet=40: insufficient=1, balance stays 30, armed=0; a subsequent bet=30 spin clears insufficient and gives balance=0.
REQ-035 Saturation: balance 950, bet=99, icons 7,7,7: 851 then 999 (clamped), last_win=990; bet=127 input deducts 99.
REQ-036 spin_start while ARMED and payout while IDLE are ignored; a same-cycle spin_start+payout in IDLE deducts exactly once and stays ARMED.
REQ-037 resetn pulsed low mid-conversion after a win: outputs return to 100 / 1,0,0, bcd_valid=1 immediately and asynchronously.
